// File: rtl/rotator_seq_amisha.sv
// ---------------------------------------------------------------------------
// rotator_seq_amisha
//
// Sequential rotate engine. It undoes the combinational barrel rotate-right
// stage on the switch/LED test board. When start_amisha is seen in IDLE, the
// block captures the operand and the amount. It then rotates the operand left
// by one bit per clock and presents the result on y_amisha together with a
// one-cycle done_amisha pulse.
//
// Optional feature macro: ROT_BIDIR_EN
//   When it is defined, the dir_amisha port is added and captured at accept.
//   dir_amisha = 0 rotates left and dir_amisha = 1 rotates right.
//   When it is undefined, the block rotates left only and has no dir_amisha
//   port.
//
// Ports:
//   clk_amisha    in   system clock, rising edge
//   reset_amisha  in   synchronous active-high reset
//   start_amisha  in   request strobe, sampled only in IDLE
//   dir_amisha    in   rotate direction (ROT_BIDIR_EN only)
//   a_amisha      in   operand [DATA_W-1:0]
//   amt_amisha    in   rotate amount [AMT_W-1:0], 0..DATA_W-1
//   y_amisha      out  registered result; changes only on entry to DONE
//   busy_amisha   out  high whenever the FSM is not in IDLE
//   done_amisha   out  one-cycle pulse; y_amisha is valid from this cycle
// ---------------------------------------------------------------------------
module rotator_seq_amisha #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 3
) (
    input  logic              clk_amisha,
    input  logic              reset_amisha,
    input  logic              start_amisha,
`ifdef ROT_BIDIR_EN
    input  logic              dir_amisha,
`endif
    input  logic [DATA_W-1:0] a_amisha,
    input  logic [AMT_W-1:0]  amt_amisha,
    output logic [DATA_W-1:0] y_amisha,
    output logic              busy_amisha,
    output logic              done_amisha
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] work_q,  work_d;
    logic [AMT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] y_q,     y_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [DATA_W-1:0] rot_w;

`ifdef ROT_BIDIR_EN
    logic              dir_q,   dir_d;

    // The direction is held from accept, so a change on dir_amisha during
    // SHIFT cannot corrupt an operation that is in progress.
    always_comb begin
        if (dir_q) begin
            rot_w = {work_q[0], work_q[DATA_W-1:1]};
        end else begin
            rot_w = {work_q[DATA_W-2:0], work_q[DATA_W-1]};
        end
    end
`else
    always_comb begin
        rot_w = {work_q[DATA_W-2:0], work_q[DATA_W-1]};
    end
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
`ifdef ROT_BIDIR_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_amisha) begin
                    work_d = a_amisha;
                    cnt_d  = amt_amisha;
`ifdef ROT_BIDIR_EN
                    dir_d  = dir_amisha;
`endif
                    // A zero amount skips SHIFT and passes the operand
                    // straight through to the result register.
                    if (amt_amisha == '0) begin
                        state_d = DONE;
                        y_d     = a_amisha;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = rot_w;
                cnt_d  = cnt_q - AMT_W'(1);
                // Leaving at cnt == 1 means the counter never wraps below
                // zero.
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                    y_d     = rot_w;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The status outputs are registered copies of the next state. This
        // makes them line up with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ROT_BIDIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ROT_BIDIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign y_amisha    = y_q;
    assign busy_amisha = busy_q;
    assign done_amisha = done_q;

endmodule

// File: tb/tb_rotator_seq_amisha.sv
// ---------------------------------------------------------------------------
// tb_rotator_seq_amisha
//
// Directed and randomized bench for rotator_seq_amisha in the default
// left-only build. Expected results come from an arithmetic rotate model, and
// expected latencies come from the amt+1 rule.
// ---------------------------------------------------------------------------
module tb_rotator_seq_amisha;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [2:0] amt_in = 3'd0;
    logic [7:0] y;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rotator_seq_amisha #(
        .DATA_W(8),
        .AMT_W (3)
    ) dut (
        .clk_amisha  (clk),
        .reset_amisha(reset),
        .start_amisha(start),
        .a_amisha    (a_in),
        .amt_amisha  (amt_in),
        .y_amisha    (y),
        .busy_amisha (busy),
        .done_amisha (done)
    );

    // Behavioural reference: rotate by amt positions using shifts on an int.
    function automatic logic [7:0] rotl(input int a, input int amt);
        int r;
        r = ((a << amt) | (a >> ((8 - amt) % 8))) & 8'hFF;
        return 8'(r);
    endfunction

    function automatic logic [7:0] rotr(input int a, input int amt);
        int r;
        r = ((a >> amt) | (a << ((8 - amt) % 8))) & 8'hFF;
        return 8'(r);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation. The task returns at the negedge that falls in the
    // done cycle, or at the negedge where the cycle budget expires.
    // lat counts cycles from the accept edge to the done cycle, and
    // busy_cycles counts the cycles sampled with busy high.
    task automatic do_op(input logic [7:0] a, input logic [2:0] amt,
                         output int lat, output int busy_cycles);
        @(negedge clk);
        start  = 1'b1;
        a_in   = a;
        amt_in = amt;
        @(negedge clk);
        start  = 1'b0;
        // Scramble the inputs after accept so the bench can see that they
        // were captured.
        a_in   = 8'($urandom);
        amt_in = 3'($urandom);
        lat = 1;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cycles++;
        end
    endtask

    int lat, bc;
    logic [7:0] ra, exp_y, pre;
    logic [2:0] ramt;
    bit seen_done;

    initial begin
        // Reset, with start pulsed during reset.
        reset = 1'b1;
        start = 1'b1;
        a_in  = 8'hFF;
        amt_in = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_y", y, 8'h00);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;
        start = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        chk("post_reset_idle", seen_done, 0);
        $display("reset: y=%0h busy=%0b done=%0b", y, busy, done);

        // Case 1: a = 8'b1000_0001, amt = 1 gives y = 8'b0000_0011.
        do_op(8'h81, 3'd1, lat, bc);
        chk("amt1_y", y, 8'h03);
        chk("amt1_lat", lat, 2);
        chk("amt1_busy_cycles", bc, 2);
        @(negedge clk);
        chk("amt1_busy_fall", busy, 0);
        chk("amt1_done_pulse", done, 0);
        $display("op a=81 amt=1 y=%0h lat=%0d busy_cycles=%0d", y, lat, bc);

        // Case 2: amt = 0 passes a straight through.
        do_op(8'hA5, 3'd0, lat, bc);
        chk("amt0_y", y, 8'hA5);
        chk("amt0_lat", lat, 1);
        $display("op a=a5 amt=0 y=%0h lat=%0d", y, lat);

        // Case 3: a = 8'h01, amt = 7 gives y = 8'h80.
        do_op(8'h01, 3'd7, lat, bc);
        chk("amt7_y", y, 8'h80);
        chk("amt7_lat", lat, 8);
        $display("op a=01 amt=7 y=%0h lat=%0d", y, lat);
        // y holds its value through idle cycles.
        @(negedge clk);
        @(negedge clk);
        chk("y_hold", y, 8'h80);

        // Case 4: start re-pulsed with a = FF while busy is ignored.
        @(negedge clk);
        start = 1'b1; a_in = 8'h01; amt_in = 3'd7;
        @(negedge clk);
        a_in = 8'hFF; amt_in = 3'd2;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("busy_ignore_y", y, 8'h80);
        chk("busy_ignore_lat", lat, 8);
        $display("op a=01 amt=7 with start re-pulsed: y=%0h lat=%0d", y, lat);
        // y becomes FF only if the held start was re-accepted after DONE.
        // Wait for that run to finish so the bench starts clean.
        for (int i = 0; i < 6; i++) @(negedge clk);

        // Case 5: reset at cycle 3 of an amt = 7 job gives no done and y = 0.
        do_op(8'h01, 3'd7, lat, bc);
        chk("pre_abort_y", y, 8'h80);
        @(negedge clk);
        start = 1'b1; a_in = 8'h01; amt_in = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_y", y, 8'h00);
        chk("abort_busy", busy, 0);
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("abort_no_done", seen_done, 0);
        $display("abort: y=%0h busy=%0b done_seen=%0b", y, busy, seen_done);

        // Randomized operations checked against the model.
        for (int i = 0; i < 40; i++) begin
            ra    = 8'($urandom);
            ramt  = 3'($urandom_range(7, 0));
            exp_y = rotl(int'(ra), int'(ramt));
            do_op(ra, ramt, lat, bc);
            chk("rand_y", y, exp_y);
            chk("rand_lat", lat, int'(ramt) + 1);
            $display("rand a=%0h amt=%0d y=%0h exp=%0h lat=%0d", ra, ramt, y, exp_y, lat);
        end

        // Round trip: rotate-left of the barrel rotate-right result recovers a.
        for (int av = 0; av < 256; av++) begin
            for (int am = 0; am < 8; am++) begin
                pre = rotr(av, am);
                do_op(pre, 3'(am), lat, bc);
                chk("round_trip", y, av);
            end
        end
        $display("round trip: 2048 operations done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rotator_seq_amisha.md
# rotator_seq_amisha

Sequential 8-bit rotate-left engine: the inverse of the team's combinational barrel rotate-right stage. It accepts a data byte and a 3-bit amount on a start strobe and rotates left one bit position per clock. It then presents the result with a one-cycle done pulse. It sits after the barrel shifter stage on the switch/LED test board, so a value rotated right by N can be rotated back by N to recover the original byte.

## Interface
Parameters:
- DATA_W, 8, data width in bits.
- AMT_W, 3, amount width; must equal log2(DATA_W).

Ports:
- clk_amisha  input  1  system clock, all logic on rising edge.
- reset_amisha  input  1  synchronous, active-high reset.
- start_amisha  input  1  request strobe, sampled only in IDLE.
- a_amisha  input  DATA_W  operand byte.
- amt_amisha  input  AMT_W  rotate amount, 0..DATA_W-1.
- y_amisha  output  DATA_W  registered result.
- busy_amisha  output  1  high whenever state != IDLE.
- done_amisha  output  1  one-cycle pulse; y_amisha valid from this cycle.
- dir_amisha  input  1  present only with ROT_BIDIR_EN; 0 = left, 1 = right.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - When start_amisha is 1, load work_reg <= a_amisha and cnt <= amt_amisha.
  - Next state is DONE if amt_amisha == 0, otherwise SHIFT.
  - When start_amisha is 0, stay in IDLE.
- SHIFT, on each edge:
  - work_reg <= {work_reg[DATA_W-2:0], work_reg[DATA_W-1]} (rotate left by 1).
  - cnt <= cnt - 1.
  - When cnt == 1, go to DONE and load y_amisha with the rotated value.
- DONE: done_amisha = 1. Next state is always IDLE.
- amt == 0 path: y_amisha <= work_reg on entry to DONE, i.e. passthrough of a_amisha.
- y_amisha changes only on entry to DONE. It holds its value through IDLE and the next operation until the next DONE.
- start_amisha while busy_amisha = 1 is ignored. It is not queued.
- Inputs a_amisha and amt_amisha are captured at accept. Later changes have no effect on the operation in progress.
- Wrap-around: bits leaving the MSB re-enter at the LSB. No bits are lost.
- The counter is AMT_W bits and never underflows, because the SHIFT exit occurs at cnt == 1.

## Timing
- Reset values: state IDLE; y_amisha = 0; busy_amisha = 0; done_amisha = 0; work_reg = 0; cnt = 0.
- Reset has priority over every other input. Asserting reset mid-SHIFT aborts the operation, returns all outputs to their reset values on the next edge, and produces no done pulse.
- Let the accept edge be E. busy_amisha goes high after E.
- done_amisha is high during the cycle after edge E+amt. This gives a latency of amt+1 cycles from accept to the done cycle; amt = 0 gives done in the cycle directly after E.
- busy_amisha falls after the edge that leaves DONE.
- Back-to-back: a new start can be accepted on the edge that leaves DONE? No — during DONE busy_amisha = 1, so start is ignored. The earliest re-accept is the first IDLE cycle.
- Throughput: one operation per amt+2 cycles maximum.

## Configuration
- ROT_BIDIR_EN defined:
  - Adds the dir_amisha port, captured at accept.
  - dir = 1 rotates right one bit per SHIFT cycle: {work_reg[0], work_reg[DATA_W-1:1]}.
  - Latency and handshake are identical to left rotation.
- ROT_BIDIR_EN undefined: the dir_amisha port is absent and the block rotates left only.

## Test plan
- Reset: hold reset_amisha high 2 cycles -> y = 8'h00, busy = 0, done = 0. Start pulsed during reset -> no effect.
- a = 8'b1000_0001, amt = 1, start -> done one cycle after the accept edge + 1, y = 8'b0000_0011; busy high for exactly 2 cycles.
- a = 8'hA5, amt = 0 -> done in the cycle after accept, y = 8'hA5. a = 8'h01, amt = 7 -> done after 8 cycles, y = 8'h80.
- Round trip: for all 256 a × 8 amt, feed the barrel rotate-right result of (a, amt) with the same amt -> y == a every time.
- Start re-pulsed with a = 8'hFF while busy on the a = 8'h01, amt = 7 job -> result still 8'h80. Reset asserted at cycle 3 of that job -> no done, y = 8'h00.
- With ROT_BIDIR_EN: a = 8'h01, amt = 1, dir = 1 -> y = 8'h80. dir = 0 -> y = 8'h02.
